program_run_monitor: RTL

PROGRAM_RUN_MONITOR -- requirements
Module: program_run_monitor

---
 rtl/program_run_monitor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/program_run_monitor.sv
// Watches a core's PC for an end-of-program address, lets the pipeline drain,
// then compares a result register against the expected value (or reports a timeout).
module program_run_monitor #(
  parameter int                                  ADDRESS_BITS   = 32,
  parameter int                                  DATA_WIDTH     = 32,
  parameter int                                  NUM_END_PCS    = 2,
  parameter logic [NUM_END_PCS*ADDRESS_BITS-1:0] END_PCS        = {32'h000000ac, 32'h000000a8},
  parameter logic [DATA_WIDTH-1:0]               EXPECTED_VALUE = 32'h00009d80,
  parameter int                                  DRAIN_CYCLES   = 50,
  parameter int                                  TIMEOUT_CYCLES = 1000,
  parameter int                                  COUNT_BITS     = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [DATA_WIDTH-1:0]   check_value,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [COUNT_BITS-1:0]   run_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [COUNT_BITS:0] TIMEOUT_W = (COUNT_BITS+1)'(TIMEOUT_CYCLES);
  localparam logic [COUNT_BITS:0] DRAIN_W   = (COUNT_BITS+1)'(DRAIN_CYCLES);
  localparam logic [COUNT_BITS:0] ONE_W     = (COUNT_BITS+1)'(1);

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   run_cnt_q, run_cnt_d;
  logic [COUNT_BITS-1:0]   drain_cnt_q, drain_cnt_d;
  logic [COUNT_BITS-1:0]   run_cycles_q, run_cycles_d;
  logic                    pass_q, pass_d;
  logic                    fail_q, fail_d;
  logic                    timeout_q, timeout_d;

  logic                    match;
  logic [COUNT_BITS:0]     run_inc;
  logic [COUNT_BITS:0]     drain_inc;
  logic [COUNT_BITS-1:0]   run_sat;

  always_comb begin
    match = 1'b0;
    for (int i = 0; i < NUM_END_PCS; i++) begin
      if (PC == END_PCS[i*ADDRESS_BITS +: ADDRESS_BITS]) match = 1'b1;
    end
  end

  // One extra bit keeps the "+1 == limit" compares exact even at counter wrap.
  assign run_inc   = {1'b0, run_cnt_q} + ONE_W;
  assign drain_inc = {1'b0, drain_cnt_q} + ONE_W;
  assign run_sat   = (&run_cnt_q) ? run_cnt_q : run_inc[COUNT_BITS-1:0];

  always_comb begin
    state_d      = state_q;
    run_cnt_d    = run_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    run_cycles_d = run_cycles_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          run_cnt_d    = '0;
          drain_cnt_d  = '0;
          run_cycles_d = '0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      RUN: begin
        run_cnt_d = run_sat;
        // A match on the final allowed cycle still counts as reaching the end.
        if (match) begin
          state_d      = DRAIN;
          run_cycles_d = run_sat;
          drain_cnt_d  = '0;
        end else if (run_inc == TIMEOUT_W) begin
          state_d      = DONE;
          run_cycles_d = TIMEOUT_W[COUNT_BITS-1:0];
          timeout_d    = 1'b1;
          fail_d       = 1'b1;
          pass_d       = 1'b0;
        end
      end
      DRAIN: begin
        drain_cnt_d = drain_inc[COUNT_BITS-1:0];
        if (drain_inc == DRAIN_W) begin
          state_d   = DONE;
          pass_d    = (check_value == EXPECTED_VALUE);
          fail_d    = (check_value != EXPECTED_VALUE);
          timeout_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      run_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      run_cycles_q <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      run_cycles_q <= run_cycles_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
    end
  end

  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;

endmodule
